pid_sequencer: RTL and testbench



---
 rtl/pid_pkg.sv | 64 ++++++
 rtl/pid_mac.sv | 72 +++++++
 rtl/pid_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pid_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pkg
//  Purpose  : Shared widths, state encoding, saturation limits and the
//             saturate helper for the BLDC speed-loop PID sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pid_pkg;

    // Datapath widths
    localparam int ERR_W  = 9;
    localparam int GAIN_W = 8;
    localparam int INT_W  = 16;
    localparam int OUT_W  = 9;
    localparam int SHIFT  = 4;

    // Shared multiplier signed operand is wide enough for error or integrator
    localparam int C_OPND_W = (INT_W > ERR_W) ? INT_W : ERR_W;
    // Product of zero-extended gain and signed operand
    localparam int C_PROD_W = GAIN_W + 1 + C_OPND_W;
    // Accumulator: three products summed, sized so it can never wrap
    localparam int C_ACC_W  = GAIN_W + INT_W + 2;

    // Output saturation limits, held at accumulator width for direct compares
    localparam logic signed [C_ACC_W-1:0] C_OUT_MAX = C_ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [C_ACC_W-1:0] C_OUT_MIN = ~C_OUT_MAX;

    // State encoding kept as explicit constants for legacy tools
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_CAP   = 3'd1;
    localparam logic [2:0] C_ST_MUL_P = 3'd2;
    localparam logic [2:0] C_ST_MUL_I = 3'd3;
    localparam logic [2:0] C_ST_MUL_D = 3'd4;
    localparam logic [2:0] C_ST_SUM   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_CAP   = C_ST_CAP,
        ST_MUL_P = C_ST_MUL_P,
        ST_MUL_I = C_ST_MUL_I,
        ST_MUL_D = C_ST_MUL_D,
        ST_SUM   = C_ST_SUM
    } state_t;

    // Clamp a signed accumulator-width value into the signed range of w bits.
    // Result stays at accumulator width; callers cast down to w bits.
    function automatic logic signed [C_ACC_W-1:0] sat(
        input logic signed [C_ACC_W-1:0] x,
        input int                        w
    );
        logic signed [C_ACC_W-1:0] hi;
        logic signed [C_ACC_W-1:0] lo;
        hi = C_ACC_W'((64'sd1 <<< (w - 1)) - 64'sd1);
        lo = ~hi;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_mac.sv
`default_nettype none
// ============================================================================
//  Module   : pid_mac
//  Purpose  : Shared multiply-accumulate for the PID terms. One multiplier is
//             steered by the sequencer state across P, I and D; the
//             accumulator clears in CAP and adds one product per MUL state.
//  Revision : 1.0  initial release
// ============================================================================
module pid_mac
    import pid_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  state_t                     i_state,
    input  logic [GAIN_W-1:0]          i_kp,
    input  logic [GAIN_W-1:0]          i_ki,
    input  logic [GAIN_W-1:0]          i_kd,
    input  logic signed [ERR_W-1:0]    i_err,
    input  logic signed [INT_W-1:0]    i_integ,
    input  logic signed [ERR_W-1:0]    i_derr,
    output logic signed [C_ACC_W-1:0]  o_acc
);

    logic [GAIN_W-1:0]          w_gain;
    logic signed [C_OPND_W-1:0] w_opnd;
    logic signed [C_PROD_W-1:0] w_prod;
    logic signed [C_ACC_W-1:0]  r_acc;

    // Operand steering: gain/term pair chosen by the current MUL state
    always_comb begin
        w_gain = '0;
        w_opnd = '0;
        case (i_state)
            ST_MUL_P: begin
                w_gain = i_kp;
                w_opnd = C_OPND_W'(i_err);
            end
            ST_MUL_I: begin
                w_gain = i_ki;
                w_opnd = C_OPND_W'(i_integ);
            end
            ST_MUL_D: begin
                w_gain = i_kd;
                w_opnd = C_OPND_W'(i_derr);
            end
            default: begin
                w_gain = '0;
                w_opnd = '0;
            end
        endcase
    end

    // Gain is unsigned, so prepend a zero before the signed multiply
    assign w_prod = $signed({1'b0, w_gain}) * w_opnd;

    // Accumulator: clear at the start of an update, add one product per term
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            case (i_state)
                ST_CAP:                     r_acc <= '0;
                ST_MUL_P, ST_MUL_I, ST_MUL_D: r_acc <= r_acc + C_ACC_W'(w_prod);
                default:                    r_acc <= r_acc;
            endcase
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pid_sequencer
//  Purpose  : One PID update per sample strobe for the BLDC speed loop.
//             Captures error, derives derivative, updates a saturating
//             integrator, sums P/I/D through a shared MAC and emits a
//             scaled, saturated control word for the PWM duty stage.
//  Options  : PID_ANTIWINDUP_EN - hold the integrator while the previous
//             output was clamped and the new error pushes further into it.
//  Revision : 1.0  initial release
// ============================================================================
module pid_sequencer
    import pid_pkg::*;
(
    input  logic                     clk_32,
    input  logic                     rst,
    input  logic                     sample_stb,
    input  logic signed [ERR_W-1:0]  err,
    input  logic [GAIN_W-1:0]        kp,
    input  logic [GAIN_W-1:0]        ki,
    input  logic [GAIN_W-1:0]        kd,
    input  logic                     integ_clr,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  u_out,
    output logic                     u_valid,
    output logic                     overrun
);

    state_t                     r_state;
    logic signed [ERR_W-1:0]    r_err;
    logic signed [ERR_W-1:0]    r_err_prev;
    logic signed [ERR_W-1:0]    r_derr;
    logic [GAIN_W-1:0]          r_kp;
    logic [GAIN_W-1:0]          r_ki;
    logic [GAIN_W-1:0]          r_kd;
    logic signed [INT_W-1:0]    r_integ;
    logic                       r_clr_pend;
    logic signed [OUT_W-1:0]    r_u_res;
    logic                       r_res_stb;
    logic signed [OUT_W-1:0]    r_u_out;
    logic                       r_u_valid;
    logic                       r_overrun;

    logic signed [C_ACC_W-1:0]  w_acc;
    logic signed [C_ACC_W-1:0]  w_acc_shr;
    logic signed [C_ACC_W-1:0]  w_err_x;
    logic signed [C_ACC_W-1:0]  w_prev_x;
    logic signed [C_ACC_W-1:0]  w_integ_x;
    logic                       w_hold;

    assign w_err_x   = C_ACC_W'(err);
    assign w_prev_x  = C_ACC_W'(r_err_prev);
    assign w_integ_x = C_ACC_W'(r_integ);
    assign w_acc_shr = w_acc >>> SHIFT;

`ifdef PID_ANTIWINDUP_EN
    logic r_sat_pos;
    logic r_sat_neg;

    // Remember which rail the most recent result was clamped to
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_sat_pos <= 1'b0;
            r_sat_neg <= 1'b0;
        end else if (r_state == ST_SUM) begin
            r_sat_pos <= (w_acc_shr > C_OUT_MAX);
            r_sat_neg <= (w_acc_shr < C_OUT_MIN);
        end
    end

    // Inhibit integration when the new error drives further into the clamp
    assign w_hold = (r_sat_pos && !err[ERR_W-1] && (err != '0)) ||
                    (r_sat_neg &&  err[ERR_W-1]);
`else
    assign w_hold = 1'b0;
`endif

    // Sequencer: fixed one-cycle walk through capture, three MACs and sum
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= sample_stb ? ST_CAP : ST_IDLE;
                ST_CAP:   r_state <= ST_MUL_P;
                ST_MUL_P: r_state <= ST_MUL_I;
                ST_MUL_I: r_state <= ST_MUL_D;
                ST_MUL_D: r_state <= ST_SUM;
                ST_SUM:   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture inputs and form the saturated derivative term
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_err      <= '0;
            r_err_prev <= '0;
            r_derr     <= '0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
        end else if (r_state == ST_CAP) begin
            r_err      <= err;
            r_err_prev <= err;
            r_derr     <= ERR_W'(sat(w_err_x - w_prev_x, ERR_W));
            r_kp       <= kp;
            r_ki       <= ki;
            r_kd       <= kd;
        end
    end

    // Integrator: immediate clear when idle, saturating update in CAP,
    // and a deferred clear on the way back to idle if one arrived while busy
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_integ <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (integ_clr) r_integ <= '0;
                ST_CAP:  if (!w_hold)   r_integ <= INT_W'(sat(w_integ_x + w_err_x, INT_W));
                ST_SUM:  if (integ_clr || r_clr_pend) r_integ <= '0;
                default: r_integ <= r_integ;
            endcase
        end
    end

    // Remember a clear request seen while an update is in flight
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst)
            r_clr_pend <= 1'b0;
        else if (r_state == ST_SUM)
            r_clr_pend <= 1'b0;
        else if ((r_state != ST_IDLE) && integ_clr)
            r_clr_pend <= 1'b1;
    end

    // Sticky overrun on any strobe that arrives while busy
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst)
            r_overrun <= 1'b0;
        else if ((r_state != ST_IDLE) && sample_stb)
            r_overrun <= 1'b1;
    end

    // Scale and clamp the accumulated sum at the end of the sequence
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_u_res   <= '0;
            r_res_stb <= 1'b0;
        end else begin
            r_res_stb <= (r_state == ST_SUM);
            if (r_state == ST_SUM)
                r_u_res <= OUT_W'(sat(w_acc_shr, OUT_W));
        end
    end

    // Output register: u_out and u_valid change together, six edges after
    // the strobe was sampled
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            r_u_out   <= '0;
            r_u_valid <= 1'b0;
        end else begin
            r_u_valid <= r_res_stb;
            if (r_res_stb)
                r_u_out <= r_u_res;
        end
    end

    pid_mac u_mac (
        .clk     (clk_32),
        .rst     (rst),
        .i_state (r_state),
        .i_kp    (r_kp),
        .i_ki    (r_ki),
        .i_kd    (r_kd),
        .i_err   (r_err),
        .i_integ (r_integ),
        .i_derr  (r_derr),
        .o_acc   (w_acc)
    );

    assign busy    = (r_state != ST_IDLE);
    assign u_out   = r_u_out;
    assign u_valid = r_u_valid;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pid_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_sequencer
//  Purpose  : Self-checking bench for pid_sequencer. Expected control words
//             come from an integer-arithmetic model of the PID update rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pid_sequencer;

    logic              clk_32 = 1'b0;
    logic              rst;
    logic              sample_stb;
    logic signed [8:0] err;
    logic [7:0]        kp;
    logic [7:0]        ki;
    logic [7:0]        kd;
    logic              integ_clr;
    logic              busy;
    logic signed [8:0] u_out;
    logic              u_valid;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_prev;
    int m_integ;
    int m_last_sat;

    pid_sequencer dut (
        .clk_32     (clk_32),
        .rst        (rst),
        .sample_stb (sample_stb),
        .err        (err),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .integ_clr  (integ_clr),
        .busy       (busy),
        .u_out      (u_out),
        .u_valid    (u_valid),
        .overrun    (overrun)
    );

    always #5 clk_32 = ~clk_32;

    function automatic int sat_i(input int x, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev     = 0;
        m_integ    = 0;
        m_last_sat = 0;
    endtask

    // One PID update in plain integer arithmetic
    task automatic model_step(input int e, input int p, input int i, input int d, output int u);
        int  derr;
        int  acc;
        int  sh;
        bit  hold;
        derr   = sat_i(e - m_prev, 9);
        m_prev = e;
        hold   = 1'b0;
`ifdef PID_ANTIWINDUP_EN
        hold = (m_last_sat > 0 && e > 0) || (m_last_sat < 0 && e < 0);
`endif
        if (!hold)
            m_integ = sat_i(m_integ + e, 16);
        acc        = p * e + i * m_integ + d * derr;
        sh         = acc >>> 4;
        m_last_sat = (sh > 255) ? 1 : ((sh < -256) ? -1 : 0);
        u          = sat_i(sh, 9);
    endtask

    // Strobe one update and check latency, busy span, pulse count and value
    task automatic run_update(input int e, input int p, input int i, input int d,
                              input bit clr_idle, input bit clr_mid, input string tag);
        int exp_u;
        int nbusy;
        int nvalid;
        int vat;
        int got;
        @(negedge clk_32);
        err        = 9'(e);
        kp         = 8'(p);
        ki         = 8'(i);
        kd         = 8'(d);
        sample_stb = 1'b1;
        integ_clr  = clr_idle;
        if (clr_idle)
            m_integ = 0;
        model_step(e, p, i, d, exp_u);
        if (clr_mid)
            m_integ = 0;
        @(negedge clk_32);
        sample_stb = 1'b0;
        integ_clr  = 1'b0;
        nbusy  = 0;
        nvalid = 0;
        vat    = -1;
        got    = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy)
                nbusy++;
            if (u_valid) begin
                nvalid++;
                if (vat < 0) begin
                    vat = k;
                    got = int'(u_out);
                end
            end
            integ_clr = (clr_mid && k == 2);
            @(negedge clk_32);
        end
        integ_clr = 1'b0;
        check({tag, "_latency"}, vat, 6);
        check({tag, "_busy_cycles"}, nbusy, 5);
        check({tag, "_valid_pulses"}, nvalid, 1);
        check({tag, "_u_out"}, got, exp_u);
    endtask

    initial begin
        int exp_u;
        int nvalid;
        int got;

        rst        = 1'b1;
        sample_stb = 1'b0;
        err        = '0;
        kp         = '0;
        ki         = '0;
        kd         = '0;
        integ_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_32);

        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_u_out", int'(u_out), 0);
        check("rst_u_valid", int'(u_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Proportional only
        run_update(45, 16, 0, 0, 1'b0, 1'b0, "p_only");

        // Derivative only
        run_update(0, 0, 0, 16, 1'b0, 1'b0, "d_only_0");
        run_update(45, 0, 0, 16, 1'b0, 1'b0, "d_only_1");
        run_update(45, 0, 0, 16, 1'b0, 1'b0, "d_only_2");

        // Integral only, from a cleared integrator
        @(negedge clk_32);
        integ_clr = 1'b1;
        m_integ   = 0;
        @(negedge clk_32);
        integ_clr = 1'b0;
        run_update(10, 0, 16, 0, 1'b0, 1'b0, "i_only_1");
        run_update(10, 0, 16, 0, 1'b0, 1'b0, "i_only_2");
        run_update(10, 0, 16, 0, 1'b0, 1'b0, "i_only_3");
        run_update(10, 0, 16, 0, 1'b1, 1'b0, "i_clr_with_stb");

        // Clear arriving mid-update takes effect afterwards
        run_update(20, 0, 16, 0, 1'b0, 1'b1, "i_clr_mid");
        run_update(5, 0, 16, 0, 1'b0, 1'b0, "i_after_mid_clr");

        // Output and derivative saturation
        run_update(255, 255, 0, 0, 1'b0, 1'b0, "sat_pos");
        run_update(-256, 255, 0, 0, 1'b0, 1'b0, "sat_neg");
        run_update(255, 0, 0, 1, 1'b0, 1'b0, "derr_pre");
        run_update(-256, 0, 0, 1, 1'b0, 1'b0, "derr_sat");

        // Drive integrator into its positive rail, then step back from it
        @(negedge clk_32);
        integ_clr = 1'b1;
        m_integ   = 0;
        @(negedge clk_32);
        integ_clr = 1'b0;
        for (int n = 0; n < 130; n++)
            run_update(255, 0, 0, 0, 1'b0, 1'b0, "integ_fill");
        run_update(-256, 0, 1, 0, 1'b0, 1'b0, "integ_rail");

        // Randomized updates
        for (int n = 0; n < 30; n++) begin
            run_update(int'($urandom_range(0, 511)) - 256,
                       int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)),
                       ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) == 0),
                       "rand");
        end

        // Overrun: second strobe two cycles after the first is ignored
        check("pre_overrun", int'(overrun), 0);
        @(negedge clk_32);
        err        = 9'sd37;
        kp         = 8'd20;
        ki         = 8'd3;
        kd         = 8'd7;
        sample_stb = 1'b1;
        model_step(37, 20, 3, 7, exp_u);
        @(negedge clk_32);
        sample_stb = 1'b0;
        nvalid = 0;
        got    = 0;
        for (int k = 0; k < 10; k++) begin
            if (u_valid) begin
                nvalid++;
                got = int'(u_out);
            end
            sample_stb = (k == 1);
            @(negedge clk_32);
        end
        sample_stb = 1'b0;
        check("ovr_valid_pulses", nvalid, 1);
        check("ovr_u_out", got, exp_u);
        check("ovr_flag", int'(overrun), 1);

        // Reset asserted while in MUL_I aborts the update
        @(negedge clk_32);
        err        = 9'sd100;
        kp         = 8'd16;
        sample_stb = 1'b1;
        @(negedge clk_32);
        sample_stb = 1'b0;
        @(negedge clk_32);
        @(negedge clk_32);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_u_out", int'(u_out), 0);
        check("abort_u_valid", int'(u_valid), 0);
        check("abort_overrun", int'(overrun), 0);
        model_reset();
        @(negedge clk_32);
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            if (u_valid)
                nvalid++;
            @(negedge clk_32);
        end
        check("abort_no_valid", nvalid, 0);

        // First sample after reset sees err_prev = 0
        run_update(100, 0, 0, 16, 1'b0, 1'b0, "post_rst_d");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
